// File: rtl/div_calc_seq_pkg.sv
// Shared phase encoding for the button-driven divider calculator.
package div_calc_seq_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        LOAD_NUM = 3'd0,
        LOAD_DEN = 3'd1,
        DIVIDE   = 3'd2,
        SHOW_QUO = 3'd3,
        SHOW_REM = 3'd4
    } state_t;

endpackage

// File: rtl/div_calc_seq_if.sv
// Button ticks in, display/status out, between the button front-end and the LED drivers.
interface div_calc_seq_if
    import div_calc_seq_pkg::*;
#(
    parameter int unsigned W = 4
);
    logic                tick_next;
    logic                tick_up;
    logic                tick_down;
    logic [W-1:0]        leds;
    logic [PHASE_W-1:0]  phase;
    logic                busy;
    logic                done;
    logic                div0;

    modport master (
        output tick_next, tick_up, tick_down,
        input  leds, phase, busy, done, div0
    );

    modport slave (
        input  tick_next, tick_up, tick_down,
        output leds, phase, busy, done, div0
    );
endinterface

// File: rtl/div_restoring.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first step is taken on the start edge, so a division occupies exactly W edges.
module div_restoring #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);
    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

    logic           accept_c;
    logic [W-1:0]   den_q;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   r_in_c;
    logic           bit_in_c;
    logic [W-1:0]   den_c;
    logic [W:0]     trial_c;
    logic           qbit_c;
    logic [W-1:0]   r_next_c;

    assign accept_c = start && !busy;

    // One restoring step; quo doubles as the dividend shift register.
    always_comb begin
        r_in_c   = rem;
        bit_in_c = quo[W-1];
        den_c    = den_q;
        if (accept_c) begin
            r_in_c   = '0;
            bit_in_c = dividend[W-1];
            den_c    = divisor;
        end
        trial_c  = {r_in_c, bit_in_c};
        qbit_c   = (trial_c >= {1'b0, den_c});
        r_next_c = qbit_c ? W'(trial_c - {1'b0, den_c}) : trial_c[W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            den_q <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                den_q <= divisor;
                quo   <= {dividend[W-2:0], qbit_c};
                rem   <= r_next_c;
                cnt   <= CW'(W - 2);
                busy  <= 1'b1;
            end else if (busy) begin
                quo <= {quo[W-2:0], qbit_c};
                rem <= r_next_c;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/div_calc_seq.sv
// Calculator sequencer: operand entry via up/down/next ticks, divide, then show quotient and remainder.
module div_calc_seq
    import div_calc_seq_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            reset,
    div_calc_seq_if.slave   bus
);
    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   num;
    logic [W-1:0]   den;
    logic [W-1:0]   num_nxt;
    logic [W-1:0]   den_nxt;
    logic [W-1:0]   leds_nxt;
    logic           inc_c;
    logic           dec_c;
    logic           start_c;
    logic           div_busy;
    logic           div_done;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_rem;

    assign inc_c = bus.tick_up && !bus.tick_down;
    assign dec_c = bus.tick_down && !bus.tick_up;

    // Next state and operand edits; an edit lands on the same edge that advances the phase.
    always_comb begin
        state_nxt = state;
        num_nxt   = num;
        den_nxt   = den;
        start_c   = 1'b0;
        case (state)
            LOAD_NUM: begin
                if (inc_c)      num_nxt = num + W'(1);
                else if (dec_c) num_nxt = num - W'(1);
                if (bus.tick_next) state_nxt = LOAD_DEN;
            end
            LOAD_DEN: begin
                if (inc_c)      den_nxt = den + W'(1);
                else if (dec_c) den_nxt = den - W'(1);
                if (bus.tick_next) begin
                    state_nxt = DIVIDE;
                    start_c   = !div_busy;
                end
            end
            DIVIDE:   if (div_done)      state_nxt = SHOW_QUO;
            SHOW_QUO: if (bus.tick_next) state_nxt = SHOW_REM;
            SHOW_REM: if (bus.tick_next) state_nxt = LOAD_NUM;
            default:                     state_nxt = LOAD_NUM;
        endcase
    end

    always_comb begin
        leds_nxt = '0;
        case (state_nxt)
            LOAD_NUM: leds_nxt = num_nxt;
            LOAD_DEN: leds_nxt = den_nxt;
            SHOW_QUO: leds_nxt = div_quo;
            SHOW_REM: leds_nxt = div_rem;
            default:  leds_nxt = '0;
        endcase
    end

    div_restoring #(.W(W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .dividend (num),
        .divisor  (den_nxt),
        .busy     (div_busy),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    // All display/status outputs are registered from the next-state values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD_NUM;
            num       <= '0;
            den       <= '0;
            bus.leds  <= '0;
            bus.phase <= LOAD_NUM;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.div0  <= 1'b0;
        end else begin
            state     <= state_nxt;
            num       <= num_nxt;
            den       <= den_nxt;
            bus.leds  <= leds_nxt;
            bus.phase <= state_nxt;
            bus.busy  <= (state_nxt == DIVIDE);
            bus.done  <= (state == DIVIDE) && (state_nxt == SHOW_QUO);
            if (start_c)
                bus.div0 <= (den_nxt == '0);
            else if ((state_nxt == LOAD_NUM) && (state != LOAD_NUM))
                bus.div0 <= 1'b0;
        end
    end

endmodule
